// File: rtl/k051962_layer_mixer_pkg.sv
// Shared definitions for the K051962 layer mixer: layer tags, priority
// modes, PRI register bit positions and the opaque-flag bundle.
package k051962_layer_mixer_pkg;

  localparam int unsigned IDX_W = 12;
  localparam int unsigned TAG_W = 3;
  localparam int unsigned REG_W = 8;

  // Winner tags as seen by the palette RAM stage.
  typedef enum logic [TAG_W-1:0] {
    LAYER_BLANK    = 3'd0,
    LAYER_BACKDROP = 3'd1,
    LAYER_B        = 3'd2,
    LAYER_A        = 3'd3,
    LAYER_OBJ      = 3'd4,
    LAYER_FIX      = 3'd5
  } layer_t;

  // Priority orders below FIX (first = highest).
  typedef enum logic [1:0] {
    MODE_OBJ_A_B = 2'd0,
    MODE_A_OBJ_B = 2'd1,
    MODE_A_B_OBJ = 2'd2,
    MODE_OBJ_B_A = 2'd3
  } mode_t;

  localparam int unsigned PRI_MODE_LSB  = 0;
  localparam int unsigned PRI_SWAP_BIT  = 2;
  localparam int unsigned PRI_OBPRI_BIT = 3;
  localparam int unsigned PRI_FORCE_BIT = 7;

  typedef struct packed {
    logic fix;
    logic obj;
    logic a;
    logic b;
  } opaque_t;

endpackage

// File: rtl/k051962_mixer_prio.sv
// Combinational priority resolver: returns the tag of the highest-priority
// opaque layer, or LAYER_BACKDROP when nothing is opaque.
//   opaque : per-layer opaque flags
//   mode   : base priority order
//   swap   : exchange the roles of planes A and B
//   obpri  : OBJ drops directly below plane A (modes 0 and 3 only)
//   tag_c  : winning layer tag
module k051962_mixer_prio
  import k051962_layer_mixer_pkg::*;
(
  input  opaque_t opaque,
  input  mode_t   mode,
  input  logic    swap,
  input  logic    obpri,
  output layer_t  tag_c
);

  layer_t x_role;
  layer_t y_role;
  layer_t p0;
  layer_t p1;
  layer_t p2;

  function automatic logic is_opaque(input layer_t l, input opaque_t o);
    case (l)
      LAYER_A:   return o.a;
      LAYER_B:   return o.b;
      LAYER_OBJ: return o.obj;
      default:   return 1'b0;
    endcase
  endfunction

  // Build the three-slot order below FIX, then pick the first opaque slot.
  always_comb begin
    x_role = swap ? LAYER_B : LAYER_A;
    y_role = swap ? LAYER_A : LAYER_B;
    p0     = LAYER_OBJ;
    p1     = x_role;
    p2     = y_role;
    case (mode)
      MODE_OBJ_A_B: begin p0 = LAYER_OBJ; p1 = x_role;    p2 = y_role;    end
      MODE_A_OBJ_B: begin p0 = x_role;    p1 = LAYER_OBJ; p2 = y_role;    end
      MODE_A_B_OBJ: begin p0 = x_role;    p1 = y_role;    p2 = LAYER_OBJ; end
      MODE_OBJ_B_A: begin p0 = LAYER_OBJ; p1 = y_role;    p2 = x_role;    end
      default:      begin p0 = LAYER_OBJ; p1 = x_role;    p2 = y_role;    end
    endcase

    // OBJ is on top in these modes; re-insert it right under the real plane A.
    if (obpri && (mode == MODE_OBJ_A_B || mode == MODE_OBJ_B_A)) begin
      if (p1 == LAYER_A) begin
        p0 = LAYER_A;   p1 = LAYER_OBJ; p2 = LAYER_B;
      end else begin
        p0 = LAYER_B;   p1 = LAYER_A;   p2 = LAYER_OBJ;
      end
    end

    tag_c = LAYER_BACKDROP;
    if (opaque.fix)              tag_c = LAYER_FIX;
    else if (is_opaque(p0, opaque)) tag_c = p0;
    else if (is_opaque(p1, opaque)) tag_c = p1;
    else if (is_opaque(p2, opaque)) tag_c = p2;
  end

endmodule

// File: rtl/k051962_layer_mixer.sv
// K051962 layer mixer: picks one pixel per dot among FIX, A, B, OBJ and the
// backdrop using a CPU-programmed, double-buffered priority register.
//   clk_24M, RES           : clock, async active-high reset
//   ce_pix                 : dot enable (one clk_24M per pixel)
//   DSA/DSB/DFI/OB + flags : layer pixels and opaque flags
//   OB_PRI                 : per-sprite "behind plane A" attribute
//   NHBK/NVBK              : active-low blanking
//   PRI_WR/PRI_AB/PRI_DIN  : CPU write port (0 = PRI, 1 = BACKDROP)
//   PRI_DOUT               : combinational shadow readback
//   PAL_IDX/PAL_LAYER      : resolved palette index and winner tag
//   NBLK_OUT               : blank delayed to match the pixel pipeline
module k051962_layer_mixer
  import k051962_layer_mixer_pkg::*;
#(
  parameter int unsigned OBJ_W       = 12,
  parameter logic [2:0]  BLANK_LAYER = 3'd0
) (
  input  logic             clk_24M,
  input  logic             RES,
  input  logic             ce_pix,
  input  logic [11:0]      DSA,
  input  logic             NSAC,
  input  logic [11:0]      DSB,
  input  logic             NSBC,
  input  logic [7:0]       DFI,
  input  logic             NFIC,
  input  logic [OBJ_W-1:0] OB,
  input  logic             NOBC,
  input  logic             OB_PRI,
  input  logic             NHBK,
  input  logic             NVBK,
  input  logic             PRI_WR,
  input  logic             PRI_AB,
  input  logic [7:0]       PRI_DIN,
  output logic [7:0]       PRI_DOUT,
  output logic [11:0]      PAL_IDX,
  output logic [2:0]       PAL_LAYER,
  output logic             NBLK_OUT
);

  logic [REG_W-1:0] pri_sh, bd_sh, pri_act, bd_act;
  logic             nhbk_q;

  logic [11:0]      dsa_q, dsb_q;
  logic [7:0]       dfi_q;
  logic [OBJ_W-1:0] ob_q;
  logic             obpri_q;
  logic             blank_q;
  opaque_t          opaque_q;

  layer_t           win_c;
  logic [IDX_W-1:0] sel_idx_c;

  assign PRI_DOUT = PRI_AB ? bd_sh : pri_sh;

  // Shadow registers take CPU writes; active copies load at the start of
  // hblank. Same-edge write and load: load sees the pre-write shadow.
  always_ff @(posedge clk_24M or posedge RES) begin
    if (RES) begin
      pri_sh  <= '0;
      bd_sh   <= '0;
      pri_act <= '0;
      bd_act  <= '0;
      nhbk_q  <= 1'b0;
    end else begin
      if (PRI_WR) begin
        if (PRI_AB) bd_sh  <= PRI_DIN;
        else        pri_sh <= PRI_DIN;
      end
      if (ce_pix) begin
        nhbk_q <= NHBK;
        if (nhbk_q && !NHBK) begin
          pri_act <= pri_sh;
          bd_act  <= bd_sh;
        end
      end
    end
  end

  // Stage 1: capture pixel inputs and composite blank.
  always_ff @(posedge clk_24M or posedge RES) begin
    if (RES) begin
      dsa_q    <= '0;
      dsb_q    <= '0;
      dfi_q    <= '0;
      ob_q     <= '0;
      obpri_q  <= 1'b0;
      blank_q  <= 1'b0;
      opaque_q <= '0;
    end else if (ce_pix) begin
      dsa_q    <= DSA;
      dsb_q    <= DSB;
      dfi_q    <= DFI;
      ob_q     <= OB;
      obpri_q  <= OB_PRI;
      blank_q  <= ~(NHBK & NVBK);
      opaque_q <= '{fix: NFIC, obj: NOBC, a: NSAC, b: NSBC};
    end
  end

  k051962_mixer_prio u_prio (
    .opaque (opaque_q),
    .mode   (mode_t'(pri_act[PRI_MODE_LSB +: 2])),
    .swap   (pri_act[PRI_SWAP_BIT]),
    .obpri  (pri_act[PRI_OBPRI_BIT] & obpri_q),
    .tag_c  (win_c)
  );

  // Palette index of the winning layer.
  always_comb begin
    sel_idx_c = '0;
    case (win_c)
      LAYER_FIX: sel_idx_c = {4'h0, dfi_q};
      LAYER_A:   sel_idx_c = dsa_q;
      LAYER_B:   sel_idx_c = dsb_q;
      LAYER_OBJ: sel_idx_c = IDX_W'(ob_q);
      default:   sel_idx_c = '0;
    endcase
  end

  // Stage 2: blanking and forced backdrop override the resolver.
  always_ff @(posedge clk_24M or posedge RES) begin
    if (RES) begin
      PAL_IDX   <= '0;
      PAL_LAYER <= '0;
      NBLK_OUT  <= 1'b0;
    end else if (ce_pix) begin
      if (blank_q) begin
        PAL_IDX   <= '0;
        PAL_LAYER <= BLANK_LAYER;
        NBLK_OUT  <= 1'b0;
      end else begin
        NBLK_OUT <= 1'b1;
        if (pri_act[PRI_FORCE_BIT] || win_c == LAYER_BACKDROP) begin
          PAL_IDX   <= {bd_act, 4'h0};
          PAL_LAYER <= LAYER_BACKDROP;
        end else begin
          PAL_IDX   <= sel_idx_c;
          PAL_LAYER <= win_c;
        end
      end
    end
  end

endmodule

// File: tb/tb_k051962_layer_mixer.sv
// Directed bench for k051962_layer_mixer with hand-computed expectations.
module tb_k051962_layer_mixer;

  logic        clk_24M = 1'b0;
  logic        RES     = 1'b1;
  logic        ce_pix  = 1'b0;
  logic [11:0] DSA     = 12'h1A1;
  logic        NSAC    = 1'b1;
  logic [11:0] DSB     = 12'h3A5;
  logic        NSBC    = 1'b1;
  logic [7:0]  DFI     = 8'h5F;
  logic        NFIC    = 1'b1;
  logic [11:0] OB      = 12'h7E2;
  logic        NOBC    = 1'b1;
  logic        OB_PRI  = 1'b0;
  logic        NHBK    = 1'b1;
  logic        NVBK    = 1'b1;
  logic        PRI_WR  = 1'b0;
  logic        PRI_AB  = 1'b0;
  logic [7:0]  PRI_DIN = 8'h00;
  logic [7:0]  PRI_DOUT;
  logic [11:0] PAL_IDX;
  logic [2:0]  PAL_LAYER;
  logic        NBLK_OUT;

  int n_tests = 0;
  int n_fail  = 0;

  k051962_layer_mixer #(.OBJ_W(12), .BLANK_LAYER(3'd0)) dut (
    .clk_24M(clk_24M), .RES(RES), .ce_pix(ce_pix),
    .DSA(DSA), .NSAC(NSAC), .DSB(DSB), .NSBC(NSBC),
    .DFI(DFI), .NFIC(NFIC), .OB(OB), .NOBC(NOBC), .OB_PRI(OB_PRI),
    .NHBK(NHBK), .NVBK(NVBK),
    .PRI_WR(PRI_WR), .PRI_AB(PRI_AB), .PRI_DIN(PRI_DIN), .PRI_DOUT(PRI_DOUT),
    .PAL_IDX(PAL_IDX), .PAL_LAYER(PAL_LAYER), .NBLK_OUT(NBLK_OUT)
  );

  always #5 clk_24M = ~clk_24M;

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_out(input string tag, input int unsigned layer, input int unsigned idx,
                           input int unsigned nblk);
    check({tag, ".layer"}, 32'(PAL_LAYER), layer);
    check({tag, ".idx"},   32'(PAL_IDX),   idx);
    check({tag, ".nblk"},  32'(NBLK_OUT),  nblk);
  endtask

  // One dot: ce_pix high for one clk_24M, then three idle clocks.
  task automatic dot();
    @(negedge clk_24M) ce_pix = 1'b1;
    @(negedge clk_24M) ce_pix = 1'b0;
    repeat (3) @(negedge clk_24M);
  endtask

  task automatic cpu_wr(input logic ab, input logic [7:0] d);
    @(negedge clk_24M);
    PRI_AB = ab; PRI_DIN = d; PRI_WR = 1'b1;
    @(negedge clk_24M);
    PRI_WR = 1'b0;
  endtask

  // Falling NHBK for one dot (loads active regs), then flush the pipe.
  task automatic hblank();
    NHBK = 1'b0; dot();
    NHBK = 1'b1; dot(); dot();
  endtask

  task automatic set_opaque(input logic f, input logic o, input logic a, input logic b);
    NFIC = f; NOBC = o; NSAC = a; NSBC = b;
  endtask

  initial begin
    // Reset values
    repeat (3) @(negedge clk_24M);
    #1 check_out("reset0", 0, 0, 0);
    check("reset0.dout", 32'(PRI_DOUT), 0);
    RES = 1'b0;

    // All opaque, mode 0: FIX wins after two dots
    dot(); dot();
    check_out("fix_win", 5, 12'h05F, 1);

    // Mid-frame reset clears outputs immediately
    @(negedge clk_24M) RES = 1'b1;
    #1 check_out("reset_mid", 0, 0, 0);
    @(negedge clk_24M) RES = 1'b0;
    dot(); dot();

    // Mode 2: B above OBJ
    cpu_wr(1'b0, 8'h02);
    set_opaque(1'b0, 1'b1, 1'b0, 1'b1);
    hblank();
    check_out("mode2", 2, 12'h3A5, 1);

    // Shadow write to mode 0 is invisible until the next hblank
    cpu_wr(1'b0, 8'h00);
    check("dout_pri0", 32'(PRI_DOUT), 8'h00);
    dot(); dot();
    check_out("mode0_pending", 2, 12'h3A5, 1);
    hblank();
    check_out("mode0_active", 4, 12'h7E2, 1);

    // Write coincident with hblank load: this line keeps old mode
    NHBK = 1'b0;
    @(negedge clk_24M);
    ce_pix = 1'b1; PRI_WR = 1'b1; PRI_AB = 1'b0; PRI_DIN = 8'h02;
    @(negedge clk_24M);
    ce_pix = 1'b0; PRI_WR = 1'b0;
    #1 check("dout_same_edge", 32'(PRI_DOUT), 8'h02);
    repeat (3) @(negedge clk_24M);
    NHBK = 1'b1; dot(); dot();
    check_out("same_edge_old", 4, 12'h7E2, 1);
    hblank();
    check_out("same_edge_new", 2, 12'h3A5, 1);

    // Backdrop with everything transparent
    cpu_wr(1'b1, 8'hC3);
    check("dout_bd", 32'(PRI_DOUT), 8'hC3);
    set_opaque(1'b0, 1'b0, 1'b0, 1'b0);
    hblank();
    check_out("backdrop", 1, 12'hC30, 1);

    // Forced backdrop with everything opaque
    cpu_wr(1'b0, 8'h80);
    set_opaque(1'b1, 1'b1, 1'b1, 1'b1);
    hblank();
    check_out("force_bd", 1, 12'hC30, 1);

    // Swap + OB_PRI: A (in the B slot) beats OBJ
    cpu_wr(1'b0, 8'h0C);
    set_opaque(1'b0, 1'b1, 1'b1, 1'b0);
    OB_PRI = 1'b1;
    hblank();
    check_out("swap_obpri1", 3, 12'h1A1, 1);
    OB_PRI = 1'b0; dot(); dot();
    check_out("swap_obpri0", 4, 12'h7E2, 1);

    // Mode 3 with reserved bits: OBJ on top, reserved bits read back
    cpu_wr(1'b0, 8'h73);
    check("dout_rsvd", 32'(PRI_DOUT), 8'h73);
    set_opaque(1'b0, 1'b0, 1'b1, 1'b1);
    hblank();
    check_out("mode3_b_over_a", 2, 12'h3A5, 1);

    // Mode 0 restore for blank test; FIX wins
    cpu_wr(1'b0, 8'h00);
    set_opaque(1'b1, 1'b1, 1'b1, 1'b1);
    hblank();
    check_out("pre_blank", 5, 12'h05F, 1);

    // One-dot vblank appears exactly once, two dots later
    NVBK = 1'b0; dot();
    check_out("blank_lat1", 5, 12'h05F, 1);
    NVBK = 1'b1; dot();
    check_out("blank_dot", 0, 0, 0);
    dot();
    check_out("blank_after", 5, 12'h05F, 1);

    // ce_pix low freezes everything
    DFI = 8'h11; NVBK = 1'b0;
    repeat (12) @(negedge clk_24M);
    check_out("freeze", 5, 12'h05F, 1);
    NVBK = 1'b1;
    dot(); dot();
    check_out("thaw", 5, 12'h011, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
